coeff_loader: RTL and testbench

Receiving end of the serial coefficient stream in the FIR datapath. On request, it drives the source's `enable`, captures one signed coefficient per cycle into a local tap register bank, and checks the stream length against the end-of-stream flag. It then presents the bank to the MAC array through a registered random-access read port. It sits between the coefficient source and the FIR tap multipliers.

---
 rtl/fir_pkg.sv | 16 +
 rtl/coeff_bank.sv | 44 ++++
 rtl/coeff_loader.sv | 112 +++++++++++
 tb/tb_coeff_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR datapath constants and the coefficient loader state type.
// The coefficient source is parameterized from these same constants.
package fir_pkg;

  localparam int COEFF_LENGTH = 20;
  localparam int COEFF_WIDTH  = 18;
  localparam int COEFF_ADDR_W = $clog2(COEFF_LENGTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

endpackage

// File: rtl/coeff_bank.sv
// Tap register bank: one write port and one registered read port.
// Out-of-range reads return zero; a same-edge read and write returns the old word.
module coeff_bank
  import fir_pkg::*;
#(
  parameter int length     = COEFF_LENGTH,
  parameter int data_width = COEFF_WIDTH,
  parameter int addr_width = COEFF_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [addr_width-1:0] waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [addr_width-1:0] raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [length];
  logic [data_width-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < length; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (int'(waddr_i) < length)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (int'(raddr_i) < length) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/coeff_loader.sv
// Receives one serial coefficient load into the tap bank and checks its length
// against the source end-of-stream flag; serves the bank to the MAC array.
module coeff_loader
  import fir_pkg::*;
#(
  parameter int length     = COEFF_LENGTH,
  parameter int data_width = COEFF_WIDTH,
  parameter int addr_width = COEFF_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_start,
  output logic                  coeff_enable,
  input  logic [data_width-1:0] coeff_in,
  input  logic                  coeff_set_flag,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_data,
  output logic                  coeff_ready,
  output logic                  load_error,
  output logic [1:0]            dbg_state
);

  localparam logic [addr_width-1:0] LAST_IDX = addr_width'(length - 1);

  loader_state_t         state_q, state_d;
  logic [addr_width-1:0] wr_idx_q, wr_idx_d;
  logic                  enable_q, enable_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;
  logic                  bank_we;
  logic                  at_last;

  assign at_last = (wr_idx_q == LAST_IDX);

  // Handshake: coeff_enable asks the source for words; the source answers one
  // cycle later, so PRIME absorbs that latency and CAPTURE takes one word per edge.
  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    enable_d = enable_q;
    ready_d  = ready_q;
    error_d  = error_q;
    bank_we  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          state_d  = PRIME;
          enable_d = 1'b1;
          ready_d  = 1'b0;
          error_d  = 1'b0;
          wr_idx_d = '0;
        end
      end
      PRIME: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        bank_we  = 1'b1;
        wr_idx_d = wr_idx_q + 1'b1;
        if (coeff_set_flag && at_last) begin
          state_d  = DONE;
          enable_d = 1'b0;
          ready_d  = 1'b1;
        end else if (coeff_set_flag || at_last) begin
          // Flag and length disagree: keep what was written, report the error.
          state_d  = IDLE;
          enable_d = 1'b0;
          error_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_idx_q <= '0;
      enable_q <= 1'b0;
      ready_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      enable_q <= enable_d;
      ready_q  <= ready_d;
      error_q  <= error_d;
    end
  end

  coeff_bank #(
    .length    (length),
    .data_width(data_width),
    .addr_width(addr_width)
  ) u_bank (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .we_i   (bank_we),
    .waddr_i(wr_idx_q),
    .wdata_i(coeff_in),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  assign coeff_enable = enable_q;
  assign coeff_ready  = ready_q;
  assign load_error   = error_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_coeff_loader.sv
// Bench for coeff_loader: the bench plays the coefficient source and checks
// every edge against a word-level model of the tap bank and load outcome.
module tb_coeff_loader;
  import fir_pkg::*;

  localparam int LEN = COEFF_LENGTH;
  localparam int NONE = -100;

  logic        clock;
  logic        reset_n;
  logic        load_start;
  logic        coeff_enable;
  logic [17:0] coeff_in;
  logic        coeff_set_flag;
  logic [4:0]  rd_addr;
  logic [17:0] rd_data;
  logic        coeff_ready;
  logic        load_error;
  logic [1:0]  dbg_state;

  logic [17:0] stim [LEN];
  logic [17:0] ref_bank [LEN];
  logic [31:0] exp_q [$];
  int          n_checks;
  int          n_pass;

  int nominal [LEN] = '{34124, 3114, 0, 4991, 2210, -7711, 15320, 81122, -42001, 1091,
                        777, -1, 23456, -65000, 512, 99999, -3333, 40000, -970, 10000};

  coeff_loader dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .load_start    (load_start),
    .coeff_enable  (coeff_enable),
    .coeff_in      (coeff_in),
    .coeff_set_flag(coeff_set_flag),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .coeff_ready   (coeff_ready),
    .load_error    (load_error),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_flags(input string tag, input logic en, input logic rdy, input logic err);
    check_val({tag, "_enable"}, 32'(coeff_enable), 32'(en));
    check_val({tag, "_ready"}, 32'(coeff_ready), 32'(rdy));
    check_val({tag, "_error"}, 32'(load_error), 32'(err));
  endtask

  task automatic load_nominal();
    for (int i = 0; i < LEN; i++) stim[i] = 18'(nominal[i]);
  endtask

  task automatic load_random();
    for (int i = 0; i < LEN; i++) stim[i] = 18'($urandom);
  endtask

  // One load as seen from the source side. flag_at: word carrying the flag
  // (NONE = never); restart_at: word during which load_start is pulsed again;
  // reset_at: word during which reset is asserted.
  task automatic do_load(input int flag_at, input int restart_at, input int reset_at);
    int  last;
    int  end_e;
    int  w;
    bit  ok;
    logic [17:0] exp_rd;
    last  = (flag_at >= 0 && flag_at < LEN) ? flag_at : LEN - 1;
    end_e = last + 2;
    ok    = (flag_at == LEN - 1);
    rd_addr = 5'd3;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check_flags("start", 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= end_e; e++) begin
      w = e - 2;
      if (w >= 0) begin
        coeff_in = stim[w];
        coeff_set_flag = (w == flag_at);
      end else begin
        coeff_in = 18'($urandom);
        coeff_set_flag = 1'($urandom_range(0, 1));
      end
      load_start = (w == restart_at);
      if (w == reset_at) begin
        reset_n = 1'b0;
        load_start = 1'b0;
        #1;
        check_flags("async_rst", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < LEN; i++) ref_bank[i] = '0;
        step();
        check_val("rst_rd", 32'(rd_data), 32'(0));
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          coeff_in = 18'($urandom);
          coeff_set_flag = 1'($urandom_range(0, 1));
          step();
          check_flags("post_rst", 1'b0, 1'b0, 1'b0);
          check_val("post_rst_state", 32'(dbg_state), 32'(IDLE));
        end
        coeff_set_flag = 1'b0;
        return;
      end
      step();
      exp_rd = ref_bank[3];
      if (w >= 0) ref_bank[w] = stim[w];
      check_val("rd_during_load", 32'(rd_data), 32'(exp_rd));
      if (e < end_e) begin
        check_flags("busy", 1'b1, 1'b0, 1'b0);
      end else begin
        check_flags("end", 1'b0, ok, !ok);
        check_val("end_state", 32'(dbg_state), ok ? 32'(DONE) : 32'(IDLE));
      end
    end
    load_start = 1'b0;
    // source runs one stale cycle after enable falls
    coeff_in = 18'($urandom);
    coeff_set_flag = 1'($urandom_range(0, 1));
    step();
    check_flags("stale", 1'b0, ok, !ok);
    coeff_set_flag = 1'b0;
  endtask

  // Read-back with a new address every cycle; expected value queued one cycle ahead.
  task automatic check_bank();
    logic [4:0]  a;
    logic [31:0] exp;
    for (int i = 0; i < LEN + 4; i++) begin
      if (i < LEN) a = 5'(i);
      else if (i == LEN) a = 5'd25;
      else a = 5'($urandom_range(LEN, 31));
      rd_addr = a;
      exp_q.push_back((int'(a) < LEN) ? 32'(ref_bank[a]) : 32'(0));
      step();
      exp = exp_q.pop_front();
      check_val($sformatf("rd_%0d", a), 32'(rd_data), exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    reset_n = 1'b0;
    load_start = 1'b0;
    coeff_in = '0;
    coeff_set_flag = 1'b0;
    rd_addr = '0;
    for (int i = 0; i < LEN; i++) ref_bank[i] = '0;
    repeat (3) @(negedge clock);
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    check_val("reset_rd", 32'(rd_data), 32'(0));
    check_val("reset_state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    step();
    check_flags("idle", 1'b0, 1'b0, 1'b0);

    // nominal load
    load_nominal();
    do_load(LEN - 1, NONE, NONE);
    check_bank();

    // reload from DONE, with an ignored load_start at word 4
    load_random();
    do_load(LEN - 1, 4, NONE);
    check_bank();

    // early flag on word 9
    load_random();
    stim[9] = 18'(1091);
    do_load(9, NONE, NONE);
    check_bank();

    // missing flag
    load_random();
    do_load(NONE, NONE, NONE);
    check_bank();

    // nominal load clears the sticky error
    load_nominal();
    do_load(LEN - 1, NONE, NONE);
    check_bank();

    // random early-flag positions
    for (int r = 0; r < 3; r++) begin
      load_random();
      do_load(int'($urandom_range(0, LEN - 1)), NONE, NONE);
      check_bank();
    end

    // reset in the middle of word 12
    load_random();
    do_load(LEN - 1, NONE, 12);
    check_bank();

    // recovery load
    load_nominal();
    do_load(LEN - 1, NONE, NONE);
    check_bank();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
